// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage RV32I pipeline.
// A shadow copy of the EX/MEM/WB control fields drives RAW / load-use detection
// against the instruction in ID, the pipeline enables and flushes, and the
// EX-stage forwarding selects. Taken branches resolve in EX and squash IF/ID and ID/EX.
module hazard_control_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16,
   parameter int ENABLE_FWD = 1
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  ex_branch_tkn,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
   } slot_t;

   logic [1:0] state, state_n;
   slot_t      ex_s, mem_s, wb_s, id_s;
   logic       id_live, hazard, stall;

   // A source matches a slot's pending write; x0 never matches.
   function automatic logic src_match(input logic used, input logic [REG_ADDR_W-1:0] src,
                                      input slot_t s);
      return used & s.valid & s.reg_write & (s.rd != '0) & (s.rd == src);
   endfunction

   // Forward select for an EX operand: MEM wins over WB; a MEM load is never a source.
   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
      if (src_match(ex_s.valid, src, mem_s) && !mem_s.mem_read) return 2'b10;
      if (src_match(ex_s.valid, src, wb_s))                      return 2'b01;
      return 2'b00;
   endfunction

   // ID is a squashed bubble while in FLUSH, whatever id_valid says.
   assign id_live = id_valid & (state != ST_FLUSH);

   // Unused sources are captured as x0 so later slot compares need no use flags.
   always_comb begin
      id_s           = '0;
      id_s.valid     = id_live;
      id_s.rd        = id_rd;
      id_s.reg_write = id_reg_write;
      id_s.mem_read  = id_mem_read;
      id_s.rs1       = id_use_rs1 ? id_rs1 : '0;
      id_s.rs2       = id_use_rs2 ? id_rs2 : '0;
   end

   // Hazard detection: load-use only with forwarding, any in-flight writer without it.
   always_comb begin
      hazard = 1'b0;
      if (ENABLE_FWD != 0) begin
         hazard = ex_s.mem_read & (src_match(id_use_rs1, id_rs1, ex_s) |
                                   src_match(id_use_rs2, id_rs2, ex_s));
      end else begin
         hazard = src_match(id_use_rs1, id_rs1, ex_s) | src_match(id_use_rs2, id_rs2, ex_s) |
                  src_match(id_use_rs1, id_rs1, mem_s) | src_match(id_use_rs2, id_rs2, mem_s) |
                  src_match(id_use_rs1, id_rs1, wb_s) | src_match(id_use_rs2, id_rs2, wb_s);
      end
      hazard = hazard & id_live;
   end

   // A taken branch overrides a stall: the stalled ID instruction is squashed anyway.
   assign stall       = hazard & ~ex_branch_tkn;
   assign pc_en       = ~stall;
   assign if_id_en    = ~stall;
   assign if_id_flush = ex_branch_tkn;
   assign id_ex_flush = stall | ex_branch_tkn;

   // EX-stage operand sources, derived from the registered shadow slots.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (ENABLE_FWD != 0) begin
         fwd_a = fwd_sel(ex_s.rs1);
         fwd_b = fwd_sel(ex_s.rs2);
      end
   end

   // Next FSM state; FLUSH lasts exactly one cycle.
   always_comb begin
      state_n = ST_RUN;
      case (state)
         ST_FLUSH: state_n = ST_RUN;
         default:  state_n = ex_branch_tkn ? ST_FLUSH : (hazard ? ST_STALL : ST_RUN);
      endcase
   end

   // FSM and shadow pipeline advance; EX takes a bubble on stall, flush or idle ID.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= ST_RUN;
         ex_s  <= '0;
         mem_s <= '0;
         wb_s  <= '0;
      end else begin
         state <= state_n;
         wb_s  <= mem_s;
         mem_s <= ex_s;
         ex_s  <= (id_ex_flush || !id_live) ? '0 : id_s;
      end
   end

   // Saturating event counters.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1))         stall_cnt <= stall_cnt + CNT_W'(1);
         if (ex_branch_tkn && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized scoreboard bench: two instances (forwarding and full interlock)
// share stimulus; a reference model of in-flight instructions predicts outputs.
`timescale 1ns/1ps
module tb_hazard_control_unit;

   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
   logic       id_reg_write = 1'b0, id_mem_read = 1'b0, ex_branch_tkn = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

   logic          pc_en[2], if_id_en[2], if_id_flush[2], id_ex_flush[2];
   logic [1:0]    fwd_a[2], fwd_b[2];
   logic [CW-1:0] stall_cnt[2], flush_cnt[2];

   always #5 CLK = ~CLK;

   for (genvar m = 0; m < 2; m++) begin : g_dut
      hazard_control_unit #(.REG_ADDR_W(5), .CNT_W(CW), .ENABLE_FWD(m)) dut (
         .CLK(CLK), .RESET_N(RESET_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
         .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
         .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_tkn(ex_branch_tkn),
         .pc_en(pc_en[m]), .if_id_en(if_id_en[m]), .if_id_flush(if_id_flush[m]),
         .id_ex_flush(id_ex_flush[m]), .fwd_a(fwd_a[m]), .fwd_b(fwd_b[m]),
         .stall_cnt(stall_cnt[m]), .flush_cnt(flush_cnt[m]));
   end

   typedef struct {
      bit v; int rd; bit wr; bit ld; int rs1; int rs2; bit u1; bit u2;
   } ins_t;

   typedef struct {
      int pc_en; int if_id_en; int if_id_flush; int id_ex_flush;
      int fa; int fb; int sc; int fc;
   } exp_t;

   // Model state per mode: in-flight instructions (0=EX, 1=MEM, 2=WB).
   ins_t h[2][3];
   bit   inflush[2];
   int   scnt[2], fcnt[2];
   bit   last_br;
   exp_t q0[$], q1[$];
   int   checks = 0, errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit prod(input ins_t p, input bit u, input int r);
      return u && p.v && p.wr && p.rd != 0 && p.rd == r;
   endfunction

   // Where an operand of the instruction now in EX should come from.
   function automatic int src_of(input int m, input bit u, input int r);
      if (prod(h[m][1], u && h[m][0].v, r) && !h[m][1].ld) return 2;
      if (prod(h[m][2], u && h[m][0].v, r))                return 1;
      return 0;
   endfunction

   task automatic model_reset();
      ins_t b = '{default: 0};
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 3; k++) h[m][k] = b;
         inflush[m] = 0; scnt[m] = 0; fcnt[m] = 0;
      end
      last_br = 0;
   endtask

   // One ID-stage cycle: drive inputs, predict both modes, advance the model.
   task automatic issue(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit wr, input bit ld, input bit br_in);
      ins_t cur, b;
      bit   br, live, haz, stall;
      exp_t e;
      @(posedge CLK); #1;
      br = br_in && !last_br;
      id_valid = v; id_rs1 = rs1[4:0]; id_rs2 = rs2[4:0]; id_use_rs1 = u1; id_use_rs2 = u2;
      id_rd = rd[4:0]; id_reg_write = wr; id_mem_read = ld; ex_branch_tkn = br;
      b = '{default: 0};
      for (int m = 0; m < 2; m++) begin
         live = v && !inflush[m];
         cur = '{v: live, rd: rd, wr: wr, ld: ld, rs1: rs1, rs2: rs2, u1: u1, u2: u2};
         haz = 0;
         if (m == 1) begin
            haz = h[m][0].ld && (prod(h[m][0], u1, rs1) || prod(h[m][0], u2, rs2));
         end else begin
            for (int k = 0; k < 3; k++)
               if (prod(h[m][k], u1, rs1) || prod(h[m][k], u2, rs2)) haz = 1;
         end
         stall = haz && live && !br;
         e.pc_en = !stall; e.if_id_en = !stall; e.if_id_flush = br; e.id_ex_flush = stall || br;
         e.fa = (m == 1) ? src_of(m, h[m][0].u1, h[m][0].rs1) : 0;
         e.fb = (m == 1) ? src_of(m, h[m][0].u2, h[m][0].rs2) : 0;
         e.sc = scnt[m]; e.fc = fcnt[m];
         if (m == 1) q1.push_back(e); else q0.push_back(e);
         if (stall && scnt[m] < SAT) scnt[m]++;
         if (br && fcnt[m] < SAT) fcnt[m]++;
         h[m][2] = h[m][1];
         h[m][1] = h[m][0];
         h[m][0] = (stall || br || !live) ? b : cur;
         inflush[m] = br;
      end
      last_br = br;
   endtask

   task automatic idle();
      issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_reset_values(input string tag);
      for (int m = 0; m < 2; m++) begin
         chk({tag, "_pc_en"}, pc_en[m], 1);
         chk({tag, "_if_id_en"}, if_id_en[m], 1);
         chk({tag, "_flushes"}, {if_id_flush[m], id_ex_flush[m]}, 0);
         chk({tag, "_fwd"}, {fwd_a[m], fwd_b[m]}, 0);
         chk({tag, "_cnts"}, {stall_cnt[m], flush_cnt[m]}, 0);
      end
   endtask

   // Monitor: every cycle each instance presents a response; compare at the falling edge.
   always @(negedge CLK) begin
      exp_t e;
      for (int m = 0; m < 2; m++) begin
         if ((m == 1 && q1.size() > 0) || (m == 0 && q0.size() > 0)) begin
            e = (m == 1) ? q1.pop_front() : q0.pop_front();
            chk($sformatf("m%0d_pc_en", m), pc_en[m], e.pc_en);
            chk($sformatf("m%0d_if_id_en", m), if_id_en[m], e.if_id_en);
            chk($sformatf("m%0d_if_id_flush", m), if_id_flush[m], e.if_id_flush);
            chk($sformatf("m%0d_id_ex_flush", m), id_ex_flush[m], e.id_ex_flush);
            chk($sformatf("m%0d_fwd_a", m), fwd_a[m], e.fa);
            chk($sformatf("m%0d_fwd_b", m), fwd_b[m], e.fb);
            chk($sformatf("m%0d_stall_cnt", m), stall_cnt[m], e.sc);
            chk($sformatf("m%0d_flush_cnt", m), flush_cnt[m], e.fc);
         end
      end
   end

   initial begin
      model_reset();
      #3 check_reset_values("reset");
      @(posedge CLK); #1 RESET_N = 1'b1;

      // lw x5,0(x1); add x6,x5,x2
      issue(1, 1, 0, 1, 0, 5, 1, 1, 0);
      issue(1, 5, 2, 1, 1, 6, 1, 0, 0);
      repeat (4) idle();
      chk("load_use_stall_cnt", stall_cnt[1], 1);
      // add x5; sub x7,x5,x5
      issue(1, 1, 2, 1, 1, 5, 1, 0, 0);
      issue(1, 5, 5, 1, 1, 7, 1, 0, 0);
      repeat (4) idle();
      // double producer of x5, then consumer
      issue(1, 1, 2, 1, 1, 5, 1, 0, 0);
      issue(1, 1, 2, 1, 1, 5, 1, 0, 0);
      issue(1, 5, 3, 1, 1, 8, 1, 0, 0);
      repeat (4) idle();
      // lw x0; add x1,x0,x0
      issue(1, 1, 0, 1, 0, 0, 1, 1, 0);
      issue(1, 0, 0, 1, 1, 1, 1, 0, 0);
      repeat (4) idle();
      // load-use pending while a branch resolves
      issue(1, 1, 0, 1, 0, 5, 1, 1, 0);
      issue(1, 5, 2, 1, 1, 6, 1, 0, 1);
      issue(1, 5, 2, 1, 1, 6, 1, 0, 0);
      repeat (4) idle();
      // addi x3,x0,1; add x4,x3,x3 (3-cycle interlock without forwarding)
      issue(1, 0, 0, 1, 0, 3, 1, 0, 0);
      repeat (4) issue(1, 3, 3, 1, 1, 4, 1, 0, 0);
      repeat (4) idle();

      repeat (200)
         issue($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);

      // Reset pulsed in the middle of an interlock stall.
      idle(); idle(); idle(); idle();
      issue(1, 0, 0, 1, 0, 3, 1, 0, 0);
      issue(1, 3, 3, 1, 1, 4, 1, 0, 0);
      @(negedge CLK); #2 RESET_N = 1'b0;
      #1 check_reset_values("mid_stall_reset");
      id_valid = 1'b0; ex_branch_tkn = 1'b0;
      model_reset();
      @(posedge CLK); #1 RESET_N = 1'b1;

      repeat (200)
         issue($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);

      @(negedge CLK); #1;
      chk("scoreboard_drained", q0.size() + q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
